des_key_sched_ctrl: RTL



---
 rtl/des_pkg.sv | 47 ++++
 rtl/des_key_perm.sv | 29 ++
 rtl/des_key_sched_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 selection tables, rotation schedule, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package des_pkg;

  localparam int NUM_ROUNDS = 16;

  // PC-1: entry i names the key bit (1 = MSB of 64) that lands in C/D bit i+1.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i names the C/D bit (1 = MSB of 56) that lands in subkey bit i+1.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount for rounds 1..16 (index 0 = round 1); sums to 28.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

  // Rotate a 28-bit half left by 1 or 2 places.
  function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  // Rotate a 28-bit half right by 1 or 2 places.
  function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_perm.sv
// PC-1 (64 -> 56) and PC-2 (56 -> 48) bit selections, independent of each other.
// Latency: combinational.
// Backpressure: none; pure wiring.
module des_key_perm
  import des_pkg::*;
(
  input  logic [63:0] key,
  output logic [55:0] pc1_out,
  input  logic [55:0] cd,
  output logic [47:0] pc2_out
);

  // PC-1: bit 1 of each vector is its MSB, so table index k maps to vector bit width-k.
  always_comb begin
    pc1_out = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_out[55-i] = key[64-PC1[i]];
    end
  end

  // PC-2: select 48 of the 56 rotated C/D bits.
  always_comb begin
    pc2_out = '0;
    for (int i = 0; i < 48; i++) begin
      pc2_out[47-i] = cd[56-PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES subkey sequencer: PC-1 load, per-round C/D rotation, PC-2, encrypt or decrypt order.
// Latency: first subkey valid 2 cycles after start; then one subkey per cycle; done 1 cycle after 16th handshake.
// Backpressure: subkey/round_idx held while subkey_valid && !subkey_ready; start ignored while busy.
module des_key_sched_ctrl #(
  parameter int NUM_ROUNDS = des_pkg::NUM_ROUNDS,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        busy,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round_idx,
  output logic        done
);
  import des_pkg::*;

  localparam logic [4:0] CNT_LAST = 5'(NUM_ROUNDS - 1);
  localparam logic [4:0] IDX_LAST = 5'(NUM_ROUNDS);

  sched_state_e state, state_nxt;

  logic [27:0] c, d, c_nxt, d_nxt;
  logic [27:0] c0, d0;
  logic        dec, dec_nxt;
  logic [4:0]  count, count_nxt;
  logic [4:0]  idx_nxt;
  logic        valid_nxt;
  logic        sk_load, key_load;
  logic        hs, last;
  logic [1:0]  sh_enc, sh_dec;
  logic [55:0] cd_pc1;
  logic [47:0] ks;

  // PC-2 sees the next C/D so the subkey register captures the key of the round being entered.
  des_key_perm u_perm (
    .key     (key_in),
    .pc1_out (cd_pc1),
    .cd      ({c_nxt, d_nxt}),
    .pc2_out (ks)
  );

  // Encrypt rotates by s[r+1] when stepping to round r+1; decrypt undoes s[r] before stepping down.
  assign sh_enc = SHIFT[round_idx[3:0]];
  assign sh_dec = SHIFT[4'(round_idx - 5'd1)];

  assign busy = (state == ST_LOAD) || (state == ST_OUT);
  assign done = (state == ST_DONE);

  // Next-state and datapath update selection.
  always_comb begin
    hs        = subkey_valid & subkey_ready;
    last      = (count == CNT_LAST);
    state_nxt = state;
    c_nxt     = c;
    d_nxt     = d;
    dec_nxt   = dec;
    count_nxt = count;
    idx_nxt   = round_idx;
    valid_nxt = subkey_valid;
    sk_load   = 1'b0;
    key_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          key_load  = 1'b1;
          c_nxt     = cd_pc1[55:28];
          d_nxt     = cd_pc1[27:0];
          dec_nxt   = decrypt;
          count_nxt = '0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Decrypt starts at K16, whose total rotation is 28, i.e. C0/D0 unchanged.
        if (dec) begin
          idx_nxt = IDX_LAST;
        end else begin
          idx_nxt = 5'd1;
          c_nxt   = rol28(c, SHIFT[0]);
          d_nxt   = rol28(d, SHIFT[0]);
        end
        sk_load   = 1'b1;
        valid_nxt = 1'b1;
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (hs) begin
          if (last) begin
            valid_nxt = 1'b0;
            state_nxt = ST_DONE;
          end else begin
            count_nxt = count + 5'd1;
            sk_load   = 1'b1;
            if (dec) begin
              c_nxt   = ror28(c, sh_dec);
              d_nxt   = ror28(d, sh_dec);
              idx_nxt = round_idx - 5'd1;
            end else begin
              c_nxt   = rol28(c, sh_enc);
              d_nxt   = rol28(d, sh_enc);
              idx_nxt = round_idx + 5'd1;
            end
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: C/D halves, loaded copy, order, counter and registered subkey stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      c            <= '0;
      d            <= '0;
      c0           <= '0;
      d0           <= '0;
      dec          <= 1'b0;
      count        <= '0;
      round_idx    <= '0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
    end else begin
      c            <= c_nxt;
      d            <= d_nxt;
      dec          <= dec_nxt;
      count        <= count_nxt;
      round_idx    <= idx_nxt;
      subkey_valid <= valid_nxt;
      if (key_load) begin
        c0 <= c_nxt;
        d0 <= d_nxt;
      end
      if (sk_load) begin
        subkey <= ks;
      end
    end
  end

  // Only the registered-output variant exists.
  a_reg_out: assert property (@(posedge clk) REG_OUT == 1'b1);

  // A presented subkey always carries a legal DES round number.
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    subkey_valid |-> (round_idx >= 5'd1 && round_idx <= IDX_LAST));

  // Sixteen encrypt rotations total 28 places, bringing C/D back to their loaded values.
  a_enc_wrap: assert property (@(posedge clk) disable iff (rst)
    (state == ST_OUT && hs && last && !dec) |-> (c == c0 && d == d0));

endmodule
